// File: rtl/xyolo_read_pkg.sv
// Shared definitions for the xyolo read-side feeder: FSM encoding and default sizes.
package xyolo_read_pkg;
  localparam int XR_CNT_W      = 16;
  localparam int XR_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } xr_state_t;
endpackage

// File: rtl/xyolo_read_if.sv
// Pipelined memory read port: request/grant address phase, in-order rvalid data phase.
interface xyolo_read_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  logic              m_req;
  logic [ADDR_W-1:0] m_addr;
  logic              m_gnt;
  logic              m_rvalid;
  logic [WORD_W-1:0] m_rdata;

  modport master (output m_req, m_addr, input m_gnt, m_rvalid, m_rdata);
  modport slave  (input m_req, m_addr, output m_gnt, m_rvalid, m_rdata);
endinterface

// File: rtl/xyolo_read_fifo.sv
// Response buffer: synchronous FIFO with a per-entry tag bit and simultaneous push/pop.
module xyolo_read_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_BITS = PTR_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [W-1:0]        push_data,
  input  logic                push_tag,
  input  logic                pop,
  output logic [W-1:0]        head_data,
  output logic                head_tag,
  output logic                empty,
  output logic [CNT_BITS-1:0] count
);
  logic [W-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0] tag_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // A push into a full buffer is only taken when the head leaves in the same cycle.
  assign rd_en = pop && !empty;
  assign wr_en = push && ((count != CNT_BITS'(DEPTH)) || rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr] <= push_data;
      tag_q[wr_ptr] <= push_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign empty     = (count == '0);
  assign head_data = mem_q[rd_ptr];
  assign head_tag  = tag_q[rd_ptr];
endmodule

// File: rtl/xyolo_read.sv
// Read-side feeder: fetches bias+weight words per kernel, buffers them under credit control,
// and presents one weight vector per handshake with the kernel bias and an ld_acc marker.
module xyolo_read
  import xyolo_read_pkg::*;
#(
  parameter int DATAPATH_W = 32,
  parameter int N_MACS     = 1,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = XR_CNT_W,
  parameter int FIFO_DEPTH = XR_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [CNT_W-1:0]             n_words,
  input  logic [CNT_W-1:0]             n_kernels,
  output logic                         busy,
  output logic                         done,
  xyolo_read_if.master                 mem,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_MACS*DATAPATH_W-1:0] flow_out_weight,
  output logic [DATAPATH_W-1:0]        flow_out_bias,
  output logic                         ld_acc
);
  localparam int WORD_W = N_MACS * DATAPATH_W;
  localparam int TOT_W  = 2 * CNT_W + 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CRD_W  = FCNT_W + 1;

  xr_state_t         state;
  logic [CNT_W-1:0]  n_words_q;
  logic [CNT_W-1:0]  n_kernels_q;
  logic [CNT_W-1:0]  rsp_idx;
  logic [CNT_W-1:0]  wt_idx;
  logic [CNT_W-1:0]  kern_idx;
  logic [TOT_W-1:0]  total_q;
  logic [TOT_W-1:0]  req_cnt;
  logic [FCNT_W-1:0] outstanding;
  logic [FCNT_W-1:0] fifo_count;
  logic [CRD_W-1:0]  credit_used;
  logic [WORD_W-1:0] head_data;
  logic              head_is_bias;
  logic              fifo_empty;
  logic              grant;
  logic              rsp_push;
  logic              bias_pop;
  logic              wt_hs;
  logic              last_req;
  logic              last_wt;

  // Every in-flight request already owns a FIFO slot, so responses can never overflow it.
  assign credit_used = CRD_W'(outstanding) + CRD_W'(fifo_count);
  assign mem.m_req   = (state == ST_FETCH) && (credit_used < CRD_W'(FIFO_DEPTH));
  assign grant       = mem.m_req && mem.m_gnt;
  assign last_req    = (req_cnt == total_q - 1'b1);
  assign rsp_push    = mem.m_rvalid && ((state == ST_FETCH) || (state == ST_DRAIN));

  xyolo_read_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push),
    .push_data (mem.m_rdata),
    .push_tag  (rsp_idx == '0),
    .pop       (bias_pop || wt_hs),
    .head_data (head_data),
    .head_tag  (head_is_bias),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Bias words are consumed internally; only weight words are offered downstream.
  assign bias_pop        = !fifo_empty && head_is_bias;
  assign out_valid       = !fifo_empty && !head_is_bias;
  assign wt_hs           = out_valid && out_ready;
  assign ld_acc          = out_valid && (wt_idx == '0);
  assign flow_out_weight = head_data;
  assign last_wt         = wt_hs && (wt_idx == n_words_q - 1'b1) && (kern_idx == n_kernels_q - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem.m_addr    <= '0;
      flow_out_bias <= '0;
      n_words_q     <= '0;
      n_kernels_q   <= '0;
      total_q       <= '0;
      req_cnt       <= '0;
      outstanding   <= '0;
      rsp_idx       <= '0;
      wt_idx        <= '0;
      kern_idx      <= '0;
    end else begin
      done <= 1'b0;
      if (grant) begin
        mem.m_addr <= mem.m_addr + 1'b1;
        req_cnt    <= req_cnt + 1'b1;
      end
      case ({grant, rsp_push})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
      if (rsp_push) rsp_idx <= (rsp_idx == n_words_q) ? '0 : rsp_idx + 1'b1;
      if (bias_pop) flow_out_bias <= head_data[DATAPATH_W-1:0];
      if (wt_hs) begin
        if (wt_idx == n_words_q - 1'b1) begin
          wt_idx   <= '0;
          kern_idx <= kern_idx + 1'b1;
        end else begin
          wt_idx <= wt_idx + 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (run) begin
            busy <= 1'b1;
            if ((n_words == '0) || (n_kernels == '0)) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state       <= ST_FETCH;
              n_words_q   <= n_words;
              n_kernels_q <= n_kernels;
              total_q     <= TOT_W'(n_kernels) * (TOT_W'(n_words) + 1'b1);
              mem.m_addr  <= base_addr;
              req_cnt     <= '0;
              rsp_idx     <= '0;
              wt_idx      <= '0;
              kern_idx    <= '0;
            end
          end
        end
        ST_FETCH: if (grant && last_req) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (last_wt) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_xyolo_read.sv
// Directed bench for xyolo_read: memory model with word[a]=a, a run-level reference model
// checked every cycle, and literal expectations for each directed scenario.
module tb_xyolo_read;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] base_addr;
  logic [15:0] n_words;
  logic [15:0] n_kernels;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] flow_out_weight;
  logic [31:0] flow_out_bias;
  logic        ld_acc;

  xyolo_read_if #(.ADDR_W(32), .WORD_W(32)) mif ();

  xyolo_read #(
    .DATAPATH_W (32),
    .N_MACS     (1),
    .ADDR_W     (32),
    .CNT_W      (16),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .run             (run),
    .base_addr       (base_addr),
    .n_words         (n_words),
    .n_kernels       (n_kernels),
    .busy            (busy),
    .done            (done),
    .mem             (mif),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .flow_out_weight (flow_out_weight),
    .flow_out_bias   (flow_out_bias),
    .ld_acc          (ld_acc)
  );

  always #5 clk = ~clk;

  int   test_id    = 0;
  int   mem_lat    = 1;
  logic rdy_toggle = 1'b0;
  logic gnt_stall  = 1'b0;

  // Memory: in-order, fixed latency per grant, data equals the word address.
  initial begin : mem_model
    logic        g;
    logic [31:0] ga;
    logic [31:0] pend_a[$];
    int          pend_t[$];
    int          ecnt;
    ecnt = 0;
    mif.m_gnt = 1'b1; mif.m_rvalid = 1'b0; mif.m_rdata = '0; out_ready = 1'b1;
    forever begin
      @(negedge clk);
      g  = mif.m_req && mif.m_gnt;
      ga = mif.m_addr;
      @(posedge clk);
      ecnt++;
      if (rst) begin
        pend_a.delete();
        pend_t.delete();
      end else if (g) begin
        pend_a.push_back(ga);
        pend_t.push_back(ecnt + mem_lat);
      end
      #1;
      if (pend_t.size() != 0 && pend_t[0] <= ecnt + 1) begin
        mif.m_rvalid = 1'b1;
        mif.m_rdata  = pend_a.pop_front();
        void'(pend_t.pop_front());
      end else begin
        mif.m_rvalid = 1'b0;
        mif.m_rdata  = '0;
      end
      mif.m_gnt = !(gnt_stall && (ecnt % 3 == 0));
      out_ready = rdy_toggle ? ecnt[0] : 1'b1;
    end
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        exp_busy = 1'b0;
  logic        done_exp = 1'b0;
  logic        prev_rst = 1'b0;
  logic [31:0] c_base;
  int          c_nw, c_nk, c_total_w, c_total_req;
  int          wi, grants_seen, rv_seen, ld_cnt;
  logic [31:0] w_log[$];
  logic [31:0] b_log[$];
  logic [31:0] a_log[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (test %0d): got 0x%0h expected 0x%0h", nm, test_id, act, exp);
    end
  endtask

  task automatic end_of_run();
    chk("n_weights", 64'(wi), 64'(c_total_w));
    chk("n_grants", 64'(grants_seen), 64'(c_total_req));
    chk("n_ld_acc", 64'(ld_cnt), (c_total_w == 0) ? 64'd0 : 64'(c_nk));
    case (test_id)
      1: begin
        chk("t1_len", 64'(w_log.size()), 64'd3);
        if (w_log.size() == 3) begin
          chk("t1_w0", w_log[0], 64'h101);
          chk("t1_w1", w_log[1], 64'h102);
          chk("t1_w2", w_log[2], 64'h103);
          chk("t1_bias", b_log[2], 64'h100);
        end
      end
      2: begin
        chk("t2_len", 64'(w_log.size()), 64'd6);
        if (w_log.size() == 6) begin
          chk("t2_w2", w_log[2], 64'h104);
          chk("t2_w5", w_log[5], 64'h108);
          chk("t2_b1", b_log[1], 64'h100);
          chk("t2_b3", b_log[3], 64'h103);
          chk("t2_b4", b_log[4], 64'h106);
        end
      end
      3: begin
        chk("t3_len", 64'(w_log.size()), 64'd9);
        if (w_log.size() == 9) begin
          chk("t3_w0", w_log[0], 64'h201);
          chk("t3_w3", w_log[3], 64'h205);
          chk("t3_w8", w_log[8], 64'h20B);
          chk("t3_b8", b_log[8], 64'h208);
        end
      end
      5: begin
        chk("t5_len", 64'(w_log.size()), 64'd4);
        if (w_log.size() == 4) begin
          chk("t5_w0", w_log[0], 64'h401);
          chk("t5_w3", w_log[3], 64'h405);
          chk("t5_b3", b_log[3], 64'h403);
        end
      end
      6: begin
        chk("t6_nreq", 64'(a_log.size()), 64'd3);
        if (a_log.size() == 3 && w_log.size() == 2) begin
          chk("t6_a0", a_log[0], 64'hFFFF_FFFE);
          chk("t6_a1", a_log[1], 64'hFFFF_FFFF);
          chk("t6_a2", a_log[2], 64'h0);
          chk("t6_w1", w_log[1], 64'h0);
          chk("t6_bias", b_log[0], 64'hFFFF_FFFE);
        end
      end
      7: begin
        chk("t7_len", 64'(w_log.size()), 64'd2);
        if (w_log.size() == 2) begin
          chk("t7_w0", w_log[0], 64'h301);
          chk("t7_w1", w_log[1], 64'h303);
        end
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin : compare
    logic        nxt_done;
    logic [31:0] ea;
    logic [31:0] eb;
    int          k, j;
    nxt_done = 1'b0;
    if (prev_rst) begin
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_m_req", 64'(mif.m_req), 64'd0);
      chk("rst_m_addr", 64'(mif.m_addr), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_ld_acc", 64'(ld_acc), 64'd0);
      chk("rst_bias", 64'(flow_out_bias), 64'd0);
    end
    if (rst) begin
      exp_busy = 1'b0;
      done_exp = 1'b0;
    end else begin
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("done", 64'(done), 64'(done_exp));
      if (done_exp) end_of_run();
      if (out_valid) begin
        if (wi >= c_total_w) begin
          chk("extra_out_valid", 64'(out_valid), 64'd0);
        end else begin
          k  = wi / c_nw;
          j  = wi % c_nw;
          eb = c_base + 32'(k * (c_nw + 1));
          ea = eb + 32'(1 + j);
          chk("weight", 64'(flow_out_weight), 64'(ea));
          chk("bias", 64'(flow_out_bias), 64'(eb));
          chk("ld_acc", 64'(ld_acc), 64'(j == 0));
          if (out_ready) begin
            w_log.push_back(flow_out_weight);
            b_log.push_back(flow_out_bias);
            if (ld_acc) ld_cnt++;
            wi++;
            if (wi == c_total_w) nxt_done = 1'b1;
          end
        end
      end else begin
        chk("ld_acc_idle", 64'(ld_acc), 64'd0);
      end
      if (!(exp_busy && grants_seen < c_total_req)) chk("spurious_m_req", 64'(mif.m_req), 64'd0);
      if (grants_seen - rv_seen >= FIFO_DEPTH) chk("credit_req", 64'(mif.m_req), 64'd0);
      if (mif.m_req && mif.m_gnt) begin
        ea = c_base + 32'(grants_seen);
        chk("m_addr", 64'(mif.m_addr), 64'(ea));
        a_log.push_back(mif.m_addr);
        grants_seen++;
      end
      if (mif.m_rvalid) rv_seen++;
      if (run && !exp_busy) begin
        exp_busy = 1'b1;
        c_base   = base_addr;
        c_nw     = int'(n_words);
        c_nk     = int'(n_kernels);
        if (c_nw == 0 || c_nk == 0) begin
          c_total_w = 0; c_total_req = 0; nxt_done = 1'b1;
        end else begin
          c_total_w = c_nw * c_nk; c_total_req = c_nk * (c_nw + 1);
        end
        wi = 0; grants_seen = 0; rv_seen = 0; ld_cnt = 0;
        w_log.delete(); b_log.delete(); a_log.delete();
      end else if (done_exp) begin
        exp_busy = 1'b0;
      end
      done_exp = nxt_done;
    end
    prev_rst = rst;
  end

  task automatic do_run(input int id, input logic [31:0] b, input int nw, input int nk,
                        input int lat, input logic tog, input logic gst, input logic xp);
    logic seen;
    test_id = id; mem_lat = lat; rdy_toggle = tog; gnt_stall = gst;
    @(posedge clk); #1;
    run = 1'b1; base_addr = b; n_words = 16'(nw); n_kernels = 16'(nk);
    @(posedge clk); #1;
    run = 1'b0;
    if (xp) begin
      repeat (3) @(posedge clk);
      #1 run = 1'b1; base_addr = 32'h500; n_words = 16'd5; n_kernels = 16'd5;
      @(posedge clk); #1 run = 1'b0;
    end
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      $display("FAIL done_timeout (test %0d): got no done, required done within 3000 cycles", id);
      $fatal(1);
    end
    @(posedge clk); #1;
  endtask

  initial begin : stim
    int g;
    rst = 1'b1; run = 1'b0; base_addr = '0; n_words = '0; n_kernels = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    do_run(1, 32'h100, 3, 1, 1, 1'b0, 1'b0, 1'b0);
    do_run(2, 32'h100, 2, 3, 1, 1'b0, 1'b0, 1'b0);
    do_run(3, 32'h200, 3, 3, 5, 1'b1, 1'b1, 1'b0);
    do_run(4, 32'h250, 0, 2, 1, 1'b0, 1'b0, 1'b0);
    do_run(4, 32'h260, 3, 0, 1, 1'b0, 1'b0, 1'b0);
    do_run(7, 32'h300, 1, 2, 1, 1'b0, 1'b0, 1'b1);
    // Abort a run with responses still in flight.
    test_id = 8; mem_lat = 5; rdy_toggle = 1'b0; gnt_stall = 1'b0;
    @(posedge clk); #1;
    run = 1'b1; base_addr = 32'h380; n_words = 16'd4; n_kernels = 16'd2;
    @(posedge clk); #1 run = 1'b0;
    g = 0;
    for (int c = 0; c < 200 && g < 4; c++) begin
      @(negedge clk);
      if (mif.m_req && mif.m_gnt) g++;
    end
    if (g < 4) begin
      $display("FAIL reset_grants: got %0d grants, required 4", g);
      $fatal(1);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    do_run(5, 32'h400, 2, 2, 1, 1'b0, 1'b0, 1'b0);
    do_run(6, 32'hFFFF_FFFE, 2, 1, 1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
